// File: rtl/instr_fetch.sv
// Instruction fetch unit: single outstanding request to instruction memory and
// a valid/ready handoff of {instr, pc} to decode, with PC redirect on handshake.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] JALR_MASK = XLEN'(32'hFFFF_FFFE);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] seq_pc_c;
  logic [XLEN-1:0] next_pc_c;
  logic            redirect_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

  assign seq_pc_c = pc_q + XLEN'(4);

  // Next-PC select; only meaningful in the decode handshake cycle
  always_comb begin
    next_pc_c  = seq_pc_c;
    redirect_c = 1'b0;
    case (PCSrc)
      PC_BRANCH: begin
        next_pc_c  = PCTarget;
        redirect_c = 1'b1;
      end
      PC_JALR: begin
        next_pc_c  = ALUResult & JALR_MASK;
        redirect_c = 1'b1;
      end
      default: next_pc_c = seq_pc_c;
    endcase
  end

  // Next-state and register updates
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    case (state_q)
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          state_d = S_REQ;
          pc_d    = {next_pc_c[XLEN-1:2], 2'b00};
          if (redirect_c && (next_pc_c[1:0] != 2'b00)) misalign_d = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem_req     = (state_q == S_REQ);
  assign imem_addr    = pc_q;
  assign instr_valid  = (state_q == S_VALID);
  assign instr        = instr_q;
  assign pc           = pc_q;
  assign pc_plus4     = seq_pc_c;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: drives memory and decode handshakes on the
// falling edge and checks outputs there against hand-computed values.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int valid_cyc = 0;
  int prev_cyc  = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .PCSrc        (PCSrc),
    .PCTarget     (PCTarget),
    .ALUResult    (ALUResult),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory returns the bitwise inverse of the address as the instruction word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  // Drive handshake-only inputs to values that would corrupt the PC if sampled.
  task automatic scramble_redirect();
    PCSrc     = 2'b01;
    PCTarget  = 32'hDEAD_BEE1;
    ALUResult = 32'h1234_5677;
  endtask

  // From S_REQ: grant, return data, and check the instruction reaches decode.
  task automatic request_load(input logic [31:0] a);
    chk("req", 32'(imem_req), 32'd1);
    chk("addr", imem_addr, a);
    chk("valid_req", 32'(instr_valid), 32'd0);
    imem_gnt = 1'b1;
    @(negedge clk);
    chk("req_wait", 32'(imem_req), 32'd0);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(a);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hBAAD_F00D;
    valid_cyc   = cyc;
    chk("valid", 32'(instr_valid), 32'd1);
    chk("instr", instr, mem_word(a));
    chk("pc", pc, a);
    chk("pc_plus4", pc_plus4, a + 32'd4);
  endtask

  // From S_VALID: consume with the given redirect, leave the DUT in S_REQ.
  task automatic handshake(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    instr_ready = 1'b1;
    PCSrc       = src;
    PCTarget    = tgt;
    ALUResult   = alu;
    @(negedge clk);
    instr_ready = 1'b0;
    scramble_redirect();
  endtask

  task automatic fetch(input logic [31:0] a, input logic [1:0] src,
                       input logic [31:0] tgt, input logic [31:0] alu);
    request_load(a);
    handshake(src, tgt, alu);
  endtask

  initial begin
    reset_n     = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    scramble_redirect();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Sequential fetch at one instruction per three cycles
    request_load(32'h0);
    prev_cyc = valid_cyc;
    handshake(2'b00, 32'h0, 32'h0);
    request_load(32'h4);
    chk("tput_0_4", 32'(valid_cyc - prev_cyc), 32'd3);
    prev_cyc = valid_cyc;
    handshake(2'b00, 32'h0, 32'h0);
    request_load(32'h8);
    chk("tput_4_8", 32'(valid_cyc - prev_cyc), 32'd3);
    handshake(2'b11, 32'h0, 32'h0);

    // Branch at 0x10 to 0x40
    fetch(32'hC, 2'b00, 32'h0, 32'h0);
    fetch(32'h10, 2'b01, 32'h40, 32'h0);
    request_load(32'h40);
    chk("br_pc_plus4", pc_plus4, 32'h44);

    // JALR with bit 0 set: cleared, no error
    handshake(2'b10, 32'h0, 32'h0000_0101);
    request_load(32'h100);
    chk("jalr_misalign", 32'(misalign_err), 32'd0);

    // JALR misaligned: flag sets, low bits forced to zero
    handshake(2'b10, 32'h0, 32'h0000_0106);
    chk("jalr_mis_set", 32'(misalign_err), 32'd1);
    request_load(32'h104);

    // Backpressure with a stray rvalid pulse
    for (int i = 0; i < 5; i++) begin
      imem_rvalid = (i == 2);
      imem_rdata  = 32'hBAD0_0000 + 32'(i);
      @(negedge clk);
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_instr", instr, mem_word(32'h104));
      chk("bp_pc", pc, 32'h104);
    end
    imem_rvalid = 1'b0;
    handshake(2'b00, 32'h0, 32'h0);

    // Grant stall in S_REQ with a stray rvalid pulse
    for (int i = 0; i < 4; i++) begin
      imem_rvalid = (i == 1);
      @(negedge clk);
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, 32'h108);
      chk("stall_instr", instr, mem_word(32'h104));
    end
    imem_rvalid = 1'b0;
    fetch(32'h108, 2'b00, 32'h0, 32'h0);
    chk("mis_sticky", 32'(misalign_err), 32'd1);

    // Reset while waiting for read data; response in flight is dropped
    chk("pre_rst_addr", imem_addr, 32'h10C);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("pre_rst_wait", 32'(imem_req), 32'd0);
    reset_n     = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_0001;
    #1;
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_misalign", 32'(misalign_err), 32'd0);
    @(negedge clk);
    chk("rst_hold_instr", instr, 32'h0000_0013);
    imem_rvalid = 1'b0;
    reset_n     = 1'b1;
    @(negedge clk);

    // First request after release goes to RESET_PC, then wrap at the top
    fetch(32'h0, 2'b01, 32'hFFFF_FFFC, 32'h0);
    chk("wrap_misalign", 32'(misalign_err), 32'd0);
    request_load(32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    handshake(2'b00, 32'h0, 32'h0);
    request_load(32'h0);
    handshake(2'b00, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Ports, in order (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- reset_n, in, 1, asynchronous, active-low reset.
- PCSrc, in, 2, next-PC select from the decoder: 00 sequential, 01 branch-taken/JAL, 10 JALR, 11 reserved.
- PCTarget, in, 32, PC-relative target for branch/JAL.
- ALUResult, in, 32, JALR target before bit-0 clear.
- imem_req, out, 1, fetch request to instruction memory.
- imem_addr, out, 32, fetch address, word aligned.
- imem_gnt, in, 1, memory accepted the request.
- imem_rvalid, in, 1, read data valid.
- imem_rdata, in, 32, fetched instruction.
- instr_valid, out, 1, instruction available to the decode stage.
- instr_ready, in, 1, decode stage consumes the instruction this cycle.
- instr, out, 32, fetched instruction; opcode = instr[6:0].
- pc, out, 32, address of instr.
- pc_plus4, out, 32, pc + 4.
- misalign_err, out, 1, sticky flag: a redirect target had bits [1:0] != 0.

Function
REQ-003 The block SHALL implement three states: S_REQ, S_WAIT and S_VALID.
REQ-004 In S_REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; on imem_gnt=1 the state SHALL become S_WAIT; otherwise it SHALL stay in S_REQ with imem_req and imem_addr held stable.
REQ-005 In S_WAIT, imem_req SHALL be 0; on imem_rvalid=1, imem_rdata SHALL be captured into instr and the state SHALL become S_VALID.
REQ-006 In S_VALID, instr_valid SHALL be 1 and instr/pc SHALL be held stable until instr_ready=1.
REQ-007 When S_VALID and instr_ready=1, the block SHALL load the next PC and enter S_REQ.
- PCSrc 00 or 11: next PC = pc + 4.
- PCSrc 01: next PC = PCTarget.
- PCSrc 10: next PC = {ALUResult[31:1], 1'b0}.
REQ-008 PCSrc, PCTarget and ALUResult SHALL be sampled only in the handshake cycle of REQ-007 and ignored at all other times.
REQ-009 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000.
REQ-010 If the selected redirect target has bits [1:0] != 0, misalign_err SHALL be set and remain set until reset; the next PC SHALL be the target with bits [1:0] forced to 00.
REQ-011 imem_rvalid outside S_WAIT and imem_gnt outside S_REQ SHALL be ignored.
REQ-012 At most one request SHALL be outstanding.
REQ-013 Minimum throughput SHALL be one instruction per 3 cycles, with imem_gnt in the request cycle and imem_rvalid on the next cycle.
REQ-014 pc_plus4 SHALL be combinational pc + 4.
REQ-015 instr_valid SHALL be a decode of state only, with no combinational path from any input.

Reset
REQ-016 While reset_n=0, the block SHALL hold: state = S_REQ, pc = RESET_PC, instr = 32'h0000_0013 (NOP), misalign_err = 0, instr_valid = 0.
REQ-017 Assertion of reset_n mid-operation SHALL take effect immediately regardless of state.
REQ-018 Any response still in flight at reset SHALL be discarded; memory is reset with the same signal.
REQ-019 On the first rising edge after reset_n deasserts, imem_req SHALL be 1 with imem_addr = RESET_PC.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Sequential: gnt in the same cycle, rvalid one cycle later, instr_ready=1, PCSrc=00. Required: imem_addr sequence 0, 4, 8; instr_valid asserted every 3rd cycle.
- Branch: at pc=32'h10 the handshake carries PCSrc=01, PCTarget=32'h40. Required: next imem_addr=32'h40 and pc_plus4=32'h44 once the instruction at 32'h40 is valid.
- JALR: PCSrc=10, ALUResult=32'h0000_0101. Required: next imem_addr=32'h100 and misalign_err stays 0.
- JALR misaligned: ALUResult=32'h0000_0106. Required: misalign_err=1 and imem_addr=32'h104.
- Backpressure and stalls: instr_ready=0 for 5 cycles with a stale imem_rvalid pulse, plus imem_gnt held low for 4 cycles in S_REQ. Required: instr and pc unchanged throughout; imem_addr stable throughout the gnt stall.
- Reset mid-operation: reset_n pulsed low in S_WAIT. Required: instr_valid=0 and pc=RESET_PC immediately; the first request after release is to RESET_PC; PC wraps correctly from 32'hFFFF_FFFC to 0.
